// File: rtl/kosei_i2s_tx.sv
// kosei_i2s_tx: Philips I2S master transmitter. 24-bit two's-complement samples are sent
// MSB-first in 32-bit slots, fed from a one-entry holding buffer with a valid/ready handshake.
module kosei_i2s_tx #(
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    input  logic [23:0] pcm_l,
    input  logic [23:0] pcm_r,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sd,
    output logic        frame_start,
    output logic        underrun
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]  div_q, div_d;
    logic        bclk_q, bclk_d;
    logic [5:0]  slot_q, slot_d;
    logic        lrclk_q, lrclk_d;
    logic        sd_q, sd_d;
    logic        frame_start_q, frame_start_d;
    logic        underrun_q, underrun_d;
    logic [23:0] frame_l_q, frame_l_d;
    logic [23:0] frame_r_q, frame_r_d;
    logic        full_q, full_d;
    logic        pcm_ready_q, pcm_ready_d;
    logic [23:0] buf_l_q, buf_l_d;
    logic [23:0] buf_r_q, buf_r_d;

    logic [5:0]  slot_next;
    logic        fall;
    logic        load;
    logic        accept;

    // Serial bit for a given slot: slot k carries word bit (24-k) for k=1..24, zero elsewhere.
    function automatic logic slot_bit(input logic [5:0] slot,
                                      input logic [23:0] word_l,
                                      input logic [23:0] word_r);
        logic [4:0]  k;
        logic [23:0] word;
        logic [4:0]  idx;
        k    = slot[4:0];
        word = slot[5] ? word_r : word_l;
        idx  = 5'd24 - k;
        if ((k >= 5'd1) && (k <= 5'd24)) begin
            slot_bit = word[idx];
        end else begin
            slot_bit = 1'b0;
        end
    endfunction

    always_comb begin
        div_d         = div_q;
        bclk_d        = bclk_q;
        slot_d        = slot_q;
        lrclk_d       = lrclk_q;
        sd_d          = sd_q;
        frame_l_d     = frame_l_q;
        frame_r_d     = frame_r_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        fall          = 1'b0;
        load          = 1'b0;
        slot_next     = slot_q + 6'd1;

        if (!enable) begin
            div_d   = 8'd0;
            bclk_d  = 1'b0;
            slot_d  = 6'd63;
            lrclk_d = 1'b0;
            sd_d    = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d  = 8'd0;
            bclk_d = ~bclk_q;
            if (bclk_q) begin
                fall    = 1'b1;
                slot_d  = slot_next;
                lrclk_d = slot_next[5];
                // Slot 0 and 32 always send 0, so the old frame registers are safe to use here.
                sd_d    = slot_bit(slot_next, frame_l_q, frame_r_q);
                if (slot_next == 6'd0) begin
                    load          = 1'b1;
                    frame_start_d = 1'b1;
                    if (full_q) begin
                        frame_l_d = buf_l_q;
                        frame_r_d = buf_r_q;
                    end else begin
                        frame_l_d  = 24'd0;
                        frame_r_d  = 24'd0;
                        underrun_d = 1'b1;
                    end
                end
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    // Holding buffer: a load drains it, an accept (only possible while empty) fills it.
    always_comb begin
        accept  = pcm_valid && pcm_ready_q;
        full_d  = full_q;
        buf_l_d = buf_l_q;
        buf_r_d = buf_r_q;
        if (load && full_q) begin
            full_d = 1'b0;
        end
        if (accept) begin
            full_d  = 1'b1;
            buf_l_d = pcm_l;
            buf_r_d = pcm_r;
        end
        pcm_ready_d = !full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= 8'd0;
            bclk_q        <= 1'b0;
            slot_q        <= 6'd63;
            lrclk_q       <= 1'b0;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            frame_l_q     <= 24'd0;
            frame_r_q     <= 24'd0;
            full_q        <= 1'b0;
            pcm_ready_q   <= 1'b1;
            buf_l_q       <= 24'd0;
            buf_r_q       <= 24'd0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            slot_q        <= slot_d;
            lrclk_q       <= lrclk_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            frame_l_q     <= frame_l_d;
            frame_r_q     <= frame_r_d;
            full_q        <= full_d;
            pcm_ready_q   <= pcm_ready_d;
            buf_l_q       <= buf_l_d;
            buf_r_q       <= buf_r_d;
        end
    end

    assign pcm_ready   = pcm_ready_q;
    assign i2s_bclk    = bclk_q;
    assign i2s_lrclk   = lrclk_q;
    assign i2s_sd      = sd_q;
    assign frame_start = frame_start_q;
    assign underrun    = underrun_q;

endmodule
